// File: rtl/keypad_defs.sv
// keypad_defs: shared keypad constants and entry FSM encodings
package keypad_defs;
  localparam logic [3:0] BCD_NONE = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int N_DIGITS_DEF = 4;
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL} entry_state_e;
endpackage

// File: rtl/bcd_entry_buffer_sync.sv
// sync_rise_detect: multi-stage synchroniser with rising-edge pulse on bit 0
module sync_rise_detect #(
  parameter int WIDTH = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-2:0] data,
  output logic             rise
);
  logic [WIDTH-1:0] stg [SYNC_STAGES];
  logic prev;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
      prev <= 1'b0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
      prev <= stg[SYNC_STAGES-1][0];
    end
  assign data = stg[SYNC_STAGES-1][WIDTH-1:1];
  assign rise = stg[SYNC_STAGES-1][0] & ~prev;
endmodule

// File: rtl/bcd_entry_buffer.sv
// bcd_entry_buffer: collects synchronised keypad digits and submits them as a code
module bcd_entry_buffer
  import keypad_defs::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [3:0]                      bcd,
  input  logic                            valid_data,
  input  logic                            enter,
  input  logic                            clear,
  output logic [4*N_DIGITS-1:0]           digits,
  output logic [$clog2(N_DIGITS+1)-1:0]   count,
  output logic                            full,
  output logic [4*N_DIGITS-1:0]           code,
  output logic                            code_valid
);
  localparam int CNT_W = $clog2(N_DIGITS+1);
  localparam int W = 4*N_DIGITS;
  localparam logic [W-1:0] ALL_NONE = {N_DIGITS{BCD_NONE}};
  entry_state_e state_q, state_d;
  logic [W-1:0] digits_q, digits_d, code_q, code_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic code_valid_q, code_valid_d;
  logic [3:0] bcd_s;
  logic digit_ev, enter_q, clear_q, enter_ev, clear_ev;
  sync_rise_detect #(.WIDTH(5), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rstn(rstn), .d({bcd, valid_data}), .data(bcd_s), .rise(digit_ev)
  );
  assign enter_ev = enter & ~enter_q;
  assign clear_ev = clear & ~clear_q;
  assign count_inc = count_q + CNT_W'(1);
  // priority: clear, then enter (only with something held), then digit
  always_comb begin
    state_d = state_q;
    digits_d = digits_q;
    count_d = count_q;
    code_d = code_q;
    code_valid_d = 1'b0;
    if (clear_ev) begin
      state_d = EMPTY;
      digits_d = ALL_NONE;
      count_d = '0;
    end else if (enter_ev && state_q != EMPTY) begin
      code_d = digits_q;
      code_valid_d = 1'b1;
      state_d = EMPTY;
      digits_d = ALL_NONE;
      count_d = '0;
    end else if (digit_ev && bcd_s <= BCD_MAX && state_q != FULL) begin
      digits_d = {digits_q[W-5:0], bcd_s};
      count_d = count_inc;
      state_d = (count_inc == CNT_W'(N_DIGITS)) ? FULL : ENTRY;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= EMPTY;
      digits_q <= ALL_NONE;
      count_q <= '0;
      code_q <= ALL_NONE;
      code_valid_q <= 1'b0;
      enter_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      digits_q <= digits_d;
      count_q <= count_d;
      code_q <= code_d;
      code_valid_q <= code_valid_d;
      enter_q <= enter;
      clear_q <= clear;
    end
  assign digits = digits_q;
  assign count = count_q;
  assign full = (count_q == CNT_W'(N_DIGITS));
  assign code = code_q;
  assign code_valid = code_valid_q;
endmodule

// File: tb/tb_bcd_entry_buffer.sv
// tb_bcd_entry_buffer: table-driven checks plus code scoreboard for bcd_entry_buffer
module tb_bcd_entry_buffer;
  logic clk = 1'b0, rstn = 1'b0, valid_data = 1'b0, enter = 1'b0, clear = 1'b0;
  logic [3:0] bcd = 4'hF;
  logic [15:0] digits, code;
  logic [2:0] count;
  logic full, code_valid;
  bcd_entry_buffer dut (
    .clk(clk), .rstn(rstn), .bcd(bcd), .valid_data(valid_data), .enter(enter),
    .clear(clear), .digits(digits), .count(count), .full(full), .code(code),
    .code_valid(code_valid)
  );
  always #5 clk = ~clk;
  typedef enum logic [1:0] {OP_KEY, OP_ENT, OP_CLR} op_e;
  typedef struct {
    op_e op;
    logic [3:0] d;
    logic push;
    logic [2:0] cnt;
    logic [15:0] dig;
  } vec_t;
  vec_t tbl [14];
  logic [15:0] exp_q [$];
  logic [15:0] last_code, prev_dig, want;
  logic cv_prev;
  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (code_valid) begin
      if (cv_prev) chk("cv_consecutive", 16'd1, 16'd0);
      if (exp_q.size() == 0) chk("cv_unexpected", code, 16'hxxxx);
      else begin
        want = exp_q.pop_front();
        chk("code_sb", code, want);
      end
    end
    cv_prev = code_valid;
  endtask
  task automatic press(input logic [3:0] d);
    bcd = d;
    valid_data = 1'b1;
    repeat (3) tick();
    valid_data = 1'b0;
    bcd = 4'hF;
    repeat (5) tick();
  endtask
  task automatic pulse(input logic e, input logic c);
    enter = e;
    clear = c;
    tick();
    enter = 1'b0;
    clear = 1'b0;
    repeat (3) tick();
  endtask
  task automatic chk_state(input string nm, input logic [2:0] c, input logic [15:0] d);
    chk({nm, "_count"}, {13'd0, count}, {13'd0, c});
    chk({nm, "_digits"}, digits, d);
    chk({nm, "_full"}, {15'd0, full}, {15'd0, c == 3'd4});
    chk({nm, "_code"}, code, last_code);
  endtask
  initial begin
    cv_prev = 1'b0;
    last_code = 16'hFFFF;
    tbl[0]  = '{OP_KEY, 4'h1, 1'b0, 3'd1, 16'hFFF1};
    tbl[1]  = '{OP_KEY, 4'h2, 1'b0, 3'd2, 16'hFF12};
    tbl[2]  = '{OP_KEY, 4'h3, 1'b0, 3'd3, 16'hF123};
    tbl[3]  = '{OP_KEY, 4'h4, 1'b0, 3'd4, 16'h1234};
    tbl[4]  = '{OP_KEY, 4'h7, 1'b0, 3'd4, 16'h1234};
    tbl[5]  = '{OP_ENT, 4'hF, 1'b1, 3'd0, 16'hFFFF};
    tbl[6]  = '{OP_KEY, 4'h5, 1'b0, 3'd1, 16'hFFF5};
    tbl[7]  = '{OP_KEY, 4'h9, 1'b0, 3'd2, 16'hFF59};
    tbl[8]  = '{OP_ENT, 4'hF, 1'b1, 3'd0, 16'hFFFF};
    tbl[9]  = '{OP_ENT, 4'hF, 1'b0, 3'd0, 16'hFFFF};
    tbl[10] = '{OP_KEY, 4'hF, 1'b0, 3'd0, 16'hFFFF};
    tbl[11] = '{OP_KEY, 4'hA, 1'b0, 3'd0, 16'hFFFF};
    tbl[12] = '{OP_KEY, 4'h3, 1'b0, 3'd1, 16'hFFF3};
    tbl[13] = '{OP_CLR, 4'hF, 1'b0, 3'd0, 16'hFFFF};
    repeat (3) tick();
    chk_state("reset", 3'd0, 16'hFFFF);
    chk("reset_cv", {15'd0, code_valid}, 16'd0);
    rstn = 1'b1;
    repeat (2) tick();
    prev_dig = 16'hFFFF;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].push) begin
        exp_q.push_back(prev_dig);
        last_code = prev_dig;
      end
      case (tbl[i].op)
        OP_KEY: press(tbl[i].d);
        OP_ENT: pulse(1'b1, 1'b0);
        default: pulse(1'b0, 1'b1);
      endcase
      chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dig);
      prev_dig = tbl[i].dig;
    end
    bcd = 4'h3;
    valid_data = 1'b1;
    repeat (50) tick();
    valid_data = 1'b0;
    bcd = 4'hF;
    repeat (5) tick();
    chk_state("held", 3'd1, 16'hFFF3);
    pulse(1'b0, 1'b1);
    press(4'h8);
    press(4'h6);
    chk_state("pre_clr_ent", 3'd2, 16'hFF86);
    pulse(1'b1, 1'b1);
    chk_state("clr_ent", 3'd0, 16'hFFFF);
    press(4'h8);
    exp_q.push_back(16'hFFF8);
    last_code = 16'hFFF8;
    bcd = 4'h5;
    valid_data = 1'b1;
    repeat (2) tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    repeat (2) tick();
    valid_data = 1'b0;
    bcd = 4'hF;
    repeat (5) tick();
    chk_state("ent_digit", 3'd0, 16'hFFFF);
    press(4'h1);
    press(4'h2);
    chk_state("pre_rst", 3'd2, 16'hFF12);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    last_code = 16'hFFFF;
    chk_state("async_rst", 3'd0, 16'hFFFF);
    chk("async_rst_cv", {15'd0, code_valid}, 16'd0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    press(4'h4);
    chk_state("post_rst", 3'd1, 16'hFFF4);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
